i2s_tdm_receiver: RTL and testbench

Parametrised I2S/TDM serial-audio receiver. It captures CHANNELS time slots per frame from an external bit clock, word-select and data line, buffers the samples in a small FIFO and presents them on an AXI4-Stream master. Each beat carries the slot index and an end-of-frame marker. It sits between the codec/ADC pins and the audio DMA or processing chain, and supersedes the fixed stereo 32-bit receiver with variable width, channel count, alignment and error reporting.

---
 rtl/i2s_tdm_receiver.sv | 159 +++++++++++++++
 tb/tb_i2s_tdm_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_receiver.sv
// i2s_tdm_receiver: I2S/TDM serial-audio capture into an AXI4-Stream master via a small show-ahead FIFO
module i2s_tdm_receiver #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SLOT_WIDTH   = 32,
   parameter int CHANNELS     = 2,
   parameter int TDATA_WIDTH  = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int JUSTIFY      = 0
) (
   input  logic                                             M_AXIS_ACLK,
   input  logic                                             M_AXIS_ARESETN,
   input  logic                                             sck,
   input  logic                                             ws,
   input  logic                                             sd,
   input  logic                                             lj,
   input  logic                                             status_clr,
   output logic                                             M_AXIS_TVALID,
   output logic [TDATA_WIDTH-1:0]                           M_AXIS_TDATA,
   output logic [((CHANNELS > 2) ? $clog2(CHANNELS) : 1)-1:0] M_AXIS_TUSER,
   output logic                                             M_AXIS_TLAST,
   input  logic                                             M_AXIS_TREADY,
   output logic                                             overflow,
   output logic                                             resync_err
);
   localparam int UW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
   localparam int BW = $clog2(SLOT_WIDTH);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = TDATA_WIDTH + UW;
   localparam logic [UW-1:0] LAST_SLOT = UW'(CHANNELS - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_WIDTH - 1);
   localparam logic [BW-1:0] SMP_BIT   = BW'(SAMPLE_WIDTH - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {SEARCH, CAPTURE, WAIT_SYNC} state_t;

   logic [2:0]              r_sck, r_ws, r_sd;
   logic                    r_rise, r_ws_prev, r_lj, r_push;
   state_t                  r_state, w_state_nx;
   logic [BW-1:0]           r_bit, w_bit_nx;
   logic [UW-1:0]           r_slot, w_slot_nx, r_push_slot;
   logic [SAMPLE_WIDTH-1:0] r_sr;
   logic                    w_lj_nx, w_shift, w_push, w_resync, w_fs, w_at_end;
   logic [EW-1:0]           r_mem [FIFO_DEPTH];
   logic [AW-1:0]           r_wp, r_rp;
   logic [AW:0]             r_cnt;
   logic [EW-1:0]           w_head;
   logic [TDATA_WIDTH-1:0]  w_fmt;
   logic                    w_valid, w_pop, w_full, w_wr, w_ovf;

   assign w_fs     = r_rise && r_ws_prev && !r_ws[2];
   assign w_at_end = (r_slot == LAST_SLOT) && (r_bit == LAST_BIT);

   // Synchronise the serial pins and derive a registered one-cycle strobe per sck rising edge
   always_ff @(posedge M_AXIS_ACLK) begin
      if (!M_AXIS_ARESETN) begin
         r_sck     <= '0;
         r_ws      <= '0;
         r_sd      <= '0;
         r_rise    <= 1'b0;
         r_ws_prev <= 1'b0;
      end else begin
         r_sck  <= {r_sck[1:0], sck};
         r_ws   <= {r_ws[1:0], ws};
         r_sd   <= {r_sd[1:0], sd};
         r_rise <= r_sck[1] && !r_sck[2];
         if (r_rise) r_ws_prev <= r_ws[2];
      end
   end

   // Frame tracking: a frame start always restarts slot 0; a normal end-of-frame start is not an error
   always_comb begin
      w_state_nx = r_state;
      w_bit_nx   = r_bit;
      w_slot_nx  = r_slot;
      w_lj_nx    = r_lj;
      w_shift    = 1'b0;
      w_push     = 1'b0;
      w_resync   = 1'b0;
      if (w_fs) begin
         w_state_nx = CAPTURE;
         w_slot_nx  = '0;
         w_lj_nx    = (r_state == SEARCH) ? lj : r_lj;
         w_resync   = (r_state == CAPTURE) && !w_at_end;
         w_shift    = w_lj_nx || ((r_state == CAPTURE) && w_at_end && (r_bit <= SMP_BIT));
         w_push     = !w_lj_nx && (r_state == CAPTURE) && w_at_end && (r_bit == SMP_BIT);
         w_bit_nx   = w_lj_nx ? BW'(1) : '0;
      end else if (r_rise && (r_state == CAPTURE)) begin
         w_shift    = r_bit <= SMP_BIT;
         w_push     = r_bit == SMP_BIT;
         w_bit_nx   = (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
         w_slot_nx  = (r_bit != LAST_BIT) ? r_slot : (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
         w_state_nx = w_at_end ? WAIT_SYNC : CAPTURE;
      end
   end

   // State, counters and the MSB-first shift register; a completed sample is staged for the FIFO
   always_ff @(posedge M_AXIS_ACLK) begin
      if (!M_AXIS_ARESETN) begin
         r_state     <= SEARCH;
         r_bit       <= '0;
         r_slot      <= '0;
         r_lj        <= 1'b0;
         r_sr        <= '0;
         r_push      <= 1'b0;
         r_push_slot <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_bit       <= w_bit_nx;
         r_slot      <= w_slot_nx;
         r_lj        <= w_lj_nx;
         r_push      <= w_push;
         if (w_shift) r_sr <= {r_sr[SAMPLE_WIDTH-2:0], r_sd[2]};
         if (w_push) r_push_slot <= r_slot;
      end
   end

   assign w_fmt   = (JUSTIFY != 0) ? (TDATA_WIDTH'(r_sr) << (TDATA_WIDTH - SAMPLE_WIDTH))
                                   : TDATA_WIDTH'($signed(r_sr));
   assign w_valid = r_cnt != '0;
   assign w_full  = r_cnt == FULL_CNT;
   assign w_pop   = w_valid && M_AXIS_TREADY;
   assign w_wr    = r_push && (!w_full || w_pop);
   assign w_ovf   = r_push && w_full && !w_pop;
   assign w_head  = r_mem[r_rp];

   // FIFO storage, written only when there is room or a pop frees a slot in the same cycle
   always_ff @(posedge M_AXIS_ACLK) begin
      if (w_wr) r_mem[r_wp] <= {w_fmt, r_push_slot};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge M_AXIS_ACLK) begin
      if (!M_AXIS_ARESETN) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
      end
   end

   // Sticky error flags; a set event wins over a simultaneous clear
   always_ff @(posedge M_AXIS_ACLK) begin
      if (!M_AXIS_ARESETN) begin
         overflow   <= 1'b0;
         resync_err <= 1'b0;
      end else begin
         overflow   <= w_ovf ? 1'b1 : status_clr ? 1'b0 : overflow;
         resync_err <= w_resync ? 1'b1 : status_clr ? 1'b0 : resync_err;
      end
   end

   assign M_AXIS_TVALID = w_valid;
   assign M_AXIS_TDATA  = w_valid ? w_head[EW-1:UW] : '0;
   assign M_AXIS_TUSER  = w_valid ? w_head[UW-1:0] : '0;
   assign M_AXIS_TLAST  = w_valid && (M_AXIS_TUSER == LAST_SLOT);
endmodule

// File: tb/tb_i2s_tdm_receiver.sv
// tb_i2s_tdm_receiver: directed stereo and TDM vectors against i2s_tdm_receiver
module tb_i2s_tdm_receiver;
   logic clk = 0, rstn = 0, sck = 0, lj = 0, clr = 0;
   logic ws0 = 1, sd0 = 0, ws1 = 1, sd1 = 0, rdy0 = 0, rdy1 = 1;
   logic v0, l0, ov0, rs0, v1, l1, ov1, rs1, pv0 = 0;
   logic [31:0] d0, d1;
   logic [0:0] u0;
   logic [2:0] u1;
   int cyc = 0, n_vec = 0, n_err = 0;
   bit qw[$], qd[$], qm[$];
   logic [35:0] q0[$], q1[$];
   int tv[$], tb[$];

   i2s_tdm_receiver u_st (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .sck(sck), .ws(ws0), .sd(sd0), .lj(lj),
      .status_clr(clr), .M_AXIS_TVALID(v0), .M_AXIS_TDATA(d0), .M_AXIS_TUSER(u0),
      .M_AXIS_TLAST(l0), .M_AXIS_TREADY(rdy0), .overflow(ov0), .resync_err(rs0)
   );

   i2s_tdm_receiver #(
      .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNELS(8), .TDATA_WIDTH(32), .FIFO_DEPTH(4), .JUSTIFY(1)
   ) u_tdm (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .sck(sck), .ws(ws1), .sd(sd1), .lj(lj),
      .status_clr(clr), .M_AXIS_TVALID(v1), .M_AXIS_TDATA(d1), .M_AXIS_TUSER(u1),
      .M_AXIS_TLAST(l1), .M_AXIS_TREADY(rdy1), .overflow(ov1), .resync_err(rs1)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp bits and beats
   always @(posedge clk) cyc <= cyc + 1;

   // Beat collection and TVALID rise time-stamps, sampled mid-cycle
   always @(negedge clk) begin
      if (v0 && rdy0) q0.push_back({d0, 3'(u0), l0});
      if (v1 && rdy1) q1.push_back({d1, u1, l1});
      if (v0 && !pv0) tv.push_back(cyc);
      pv0 <= v0;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic add(input bit w, input logic [31:0] s, input int sw, input int n);
      for (int b = 0; b < n; b++) begin
         qw.push_back(w);
         qd.push_back(b < sw ? s[sw-1-b] : 1'b0);
         qm.push_back(b == sw - 1);
      end
   endtask

   task automatic clear_all();
      qw.delete(); qd.delete(); qm.delete();
      q0.delete(); q1.delete(); tv.delete(); tb.delete();
   endtask

   task automatic play(input int tgt, input bit ljm, input int rst_at, input logic [31:0] head);
      bit w;
      for (int p = 0; p < qw.size(); p++) begin
         if (p == rst_at) begin
            chk("rst_pre_tvalid", v0, 1);
            chk("rst_pre_head", d0, head);
            rstn = 0;
            @(posedge clk); #1 rstn = 1;
            chk("rst_tvalid", v0, 0);
            chk("rst_tdata", d0, 0);
            chk("rst_flags", {ov0, rs0}, 0);
            rdy0 = 1;
         end
         w = ljm ? qw[p] : (p + 1 < qw.size() ? qw[p+1] : 1'b1);
         if (tgt == 0) begin ws0 = w; sd0 = qd[p]; end
         else begin ws1 = w; sd1 = qd[p]; end
         repeat (4) @(posedge clk);
         #1 sck = 1;
         if (qm[p]) tb.push_back(cyc);
         repeat (4) @(posedge clk);
         #1 sck = 0;
      end
   endtask

   task automatic pulse(input int idx);
      int n = 0;
      while (tb.size() <= idx && n < 20000) begin @(posedge clk); #1; n++; end
      if (tb.size() <= idx) chk("pulse_timeout", tb.size(), idx + 1);
      else begin
         while (cyc < tb[idx] + 4) begin @(posedge clk); #1; end
         rdy0 = 1;
         @(posedge clk); #1 rdy0 = 0;
      end
   endtask

   task automatic stereo3();
      add(1, 0, 0, 3);
      for (int k = 1; k <= 6; k++) add(k[0] ? 1'b0 : 1'b1, 32'h111111 * k, 24, 32);
      add(1, 0, 0, 3);
   endtask

   task automatic check_seq(input int n);
      chk("ovf_beats", q0.size(), n);
      for (int k = 1; k <= n; k++)
         chk($sformatf("ovf_beat%0d", k), k <= q0.size() ? q0[k-1] : '1,
             {32'h111111 * k, 3'(k[0] ? 0 : 1), k[0] ? 1'b0 : 1'b1});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tvalid", v0, 0);
      chk("reset_tdata", d0, 0);
      chk("reset_tuser_tlast", {u0, l0}, 0);
      chk("reset_flags", {ov0, rs0}, 0);
      chk("reset_tdm_tvalid", v1, 0);
      rstn = 1;
      repeat (2) @(posedge clk);
      #1;

      clear_all();
      add(1, 0, 0, 3); add(0, 32'h800001, 24, 32); add(1, 32'h7FFFFF, 24, 32); add(1, 0, 0, 3);
      rdy0 = 1;
      play(0, 0, -1, 0);
      chk("st_beats", q0.size(), 2);
      chk("st_left", q0.size() > 0 ? q0[0] : '1, {32'hFF800001, 3'd0, 1'b0});
      chk("st_right", q0.size() > 1 ? q0[1] : '1, {32'h007FFFFF, 3'd1, 1'b1});
      for (int i = 0; i < 2; i++)
         chk($sformatf("st_latency%0d", i), (tv.size() > i && tb.size() > i) ? tv[i] - tb[i] : -1, 5);
      chk("st_no_resync", rs0, 0);

      clear_all();
      lj = 1;
      add(1, 0, 0, 3);
      for (int f = 0; f < 2; f++)
         for (int n = 0; n < 8; n++) add(n == 0 ? 1'b0 : 1'b1, 32'h1111 * n, 16, 32);
      add(1, 0, 0, 3);
      play(1, 1, -1, 0);
      lj = 0;
      chk("tdm_beats", q1.size(), 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("tdm_beat%0d", i), i < q1.size() ? q1[i] : '1,
             {(32'h1111 * (i % 8)) << 16, 3'(i % 8), (i % 8) == 7});
      chk("tdm_flags", {ov1, rs1}, 0);

      clear_all();
      add(1, 0, 0, 3); add(0, 32'h123456, 24, 32); add(1, 32'h654321, 24, 11);
      add(0, 32'hC00000, 24, 32); add(1, 32'h555555, 24, 32); add(1, 0, 0, 3);
      play(0, 0, -1, 0);
      chk("early_beats", q0.size(), 3);
      chk("early_s0", q0.size() > 0 ? q0[0] : '1, {32'h00123456, 3'd0, 1'b0});
      chk("early_next_s0", q0.size() > 1 ? q0[1] : '1, {32'hFFC00000, 3'd0, 1'b0});
      chk("early_next_s1", q0.size() > 2 ? q0[2] : '1, {32'h00555555, 3'd1, 1'b1});
      chk("early_resync", rs0, 1);
      clr = 1;
      @(posedge clk); #1 clr = 0;
      chk("early_clr", rs0, 0);

      clear_all();
      rdy0 = 0;
      stereo3();
      play(0, 0, -1, 0);
      chk("ovf_tvalid", v0, 1);
      chk("ovf_flag", ov0, 1);
      chk("ovf_head", d0, 32'h111111);
      chk("ovf_no_resync", rs0, 0);
      rdy0 = 1;
      repeat (10) @(posedge clk);
      #1;
      check_seq(4);
      chk("ovf_drained", v0, 0);
      clr = 1;
      @(posedge clk); #1 clr = 0;
      chk("ovf_clr", ov0, 0);

      clear_all();
      rdy0 = 0;
      stereo3();
      fork
         play(0, 0, -1, 0);
         begin pulse(4); pulse(5); end
      join
      chk("full_pop_no_ovf", ov0, 0);
      rdy0 = 1;
      repeat (10) @(posedge clk);
      #1;
      check_seq(6);

      clear_all();
      rdy0 = 0;
      add(1, 0, 0, 3); add(0, 32'h0ABCDE, 24, 32); add(1, 32'h765432, 24, 32);
      add(0, 32'h111111, 24, 32); add(1, 32'h222222, 24, 32); add(1, 0, 0, 4);
      add(0, 32'h876543, 24, 32); add(1, 32'h012345, 24, 32); add(1, 0, 0, 3);
      play(0, 0, 3 + 64 + 12, 32'h000ABCDE);
      chk("rst_beats", q0.size(), 2);
      chk("rst_first_s0", q0.size() > 0 ? q0[0] : '1, {32'hFF876543, 3'd0, 1'b0});
      chk("rst_then_s1", q0.size() > 1 ? q0[1] : '1, {32'h00012345, 3'd1, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
